// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
//
// A bank of CHANNELS counters driven by one shared free-running prescaler.
// Every 2^LOG2DELAY enabled cycles the prescaler raises an advance strobe.
// On that strobe channel i steps by i+1, up or down. Each channel either wraps
// or saturates at its limit. Any channel can be loaded on its own, and each
// channel keeps a sticky overflow/underflow flag.
//
// Ports
//   clk_i        rising-edge clock for all state
//   rst_i        synchronous active-high reset; overrides every other input
//   en_i         prescaler enable
//   dir_i        1 = count up, 0 = count down (all channels, sampled on advance)
//   load_i       load strobe for the channel selected by ch_sel_i
//   ch_sel_i     channel index used by load_i and count_sel_o
//   load_val_i   value written by a load
//   clr_flags_i  clears all overflow flags (a new event in the same cycle wins)
//   tick_o       one-cycle pulse in the cycle after an advance
//   count_o      all counters; channel i sits at [i*BITS +: BITS]
//   count_sel_o  count of channel ch_sel_i; 0 when ch_sel_i is out of range
//   ovf_flags_o  sticky per-channel overflow/underflow flags
//   parity_o     XOR of all count_o bits, registered (one cycle behind count_o)
// -----------------------------------------------------------------------------
module counter_bank #(
   parameter int CHANNELS  = 4,
   parameter int BITS      = 4,
   parameter int LOG2DELAY = 22,
   parameter bit SATURATE  = 1'b0,
   localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic                     dir_i,
   input  logic                     load_i,
   input  logic [SEL_W-1:0]         ch_sel_i,
   input  logic [BITS-1:0]          load_val_i,
   input  logic                     clr_flags_i,
   output logic                     tick_o,
   output logic [CHANNELS*BITS-1:0] count_o,
   output logic [BITS-1:0]          count_sel_o,
   output logic [CHANNELS-1:0]      ovf_flags_o,
   output logic                     parity_o
);

   logic [LOG2DELAY-1:0] presc_q, presc_d;
   logic                 adv;
   logic [BITS-1:0]      cnt_q [CHANNELS];
   logic [BITS-1:0]      cnt_d [CHANNELS];
   logic [CHANNELS-1:0]  ovf_q, ovf_d;
   logic                 tick_q;
   logic                 parity_q;

   // Prescaler: advance fires in the last cycle of each enabled period.
   always_comb begin
      presc_d = en_i ? presc_q + LOG2DELAY'(1) : presc_q;
      adv     = en_i & (&presc_q);
   end

   // Per-channel next state. Sums are formed one bit wider than the counter so
   // the top bit is the carry (up) or the borrow (down), which is exactly the
   // overflow/underflow event.
   always_comb begin
      logic [BITS:0] step;
      logic [BITS:0] sum;
      logic [BITS:0] diff;
      logic          evt;
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      step  = '0;
      sum   = '0;
      diff  = '0;
      evt   = 1'b0;
      ovf_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         step     = (BITS+1)'(i + 1);
         sum      = {1'b0, cnt_q[i]} + step;
         diff     = {1'b0, cnt_q[i]} - step;
         evt      = 1'b0;
         cnt_d[i] = cnt_q[i];
         // A load takes priority over an advance and suppresses its event.
         // Out-of-range indices never match any channel, so they are ignored.
         if (load_i && (ch_sel_i == SEL_W'(i))) begin
            cnt_d[i] = load_val_i;
         end else if (adv) begin
            if (dir_i) begin
               evt      = sum[BITS];
               cnt_d[i] = (SATURATE && sum[BITS]) ? '1 : sum[BITS-1:0];
            end else begin
               evt      = diff[BITS];
               cnt_d[i] = (SATURATE && diff[BITS]) ? '0 : diff[BITS-1:0];
            end
         end
         ovf_d[i] = (ovf_q[i] & ~clr_flags_i) | evt;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q  <= '0;
         tick_q   <= 1'b0;
         parity_q <= 1'b0;
         ovf_q    <= '0;
         // NOTE: the counter array is a set of flops, not a RAM, so it is
         // reset element by element like any other register.
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         presc_q  <= presc_d;
         tick_q   <= adv;
         parity_q <= ^count_o;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign count_o[g*BITS +: BITS] = cnt_q[g];
   end

   // Read-back mux; falls through to 0 when ch_sel_i names no channel.
   always_comb begin
      count_sel_o = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch_sel_i == SEL_W'(i)) begin
            count_sel_o = cnt_q[i];
         end
      end
   end

   assign tick_o      = tick_q;
   assign ovf_flags_o = ovf_q;
   assign parity_o    = parity_q;

endmodule

// File: tb/tb_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_counter_bank
//
// Three instances share one stimulus stream with a 4-cycle advance period:
//   dut_w : CHANNELS=4, wrapping
//   dut_s : CHANNELS=4, saturating
//   dut_t : CHANNELS=3, wrapping (ch_sel=3 is out of range here)
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_counter_bank;

   logic       clk = 1'b0;
   logic       rst, en, dir, load, clr_flags;
   logic [1:0] ch_sel;
   logic [3:0] load_val;

   logic        tick_w, parity_w, tick_s, parity_s, tick_t, parity_t;
   logic [15:0] count_w, count_s;
   logic [11:0] count_t;
   logic [3:0]  count_sel_w, count_sel_s, count_sel_t;
   logic [3:0]  ovf_w, ovf_s;
   logic [2:0]  ovf_t;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   counter_bank #(.CHANNELS(4), .BITS(4), .LOG2DELAY(2), .SATURATE(1'b0)) dut_w (
      .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
      .ch_sel_i(ch_sel), .load_val_i(load_val), .clr_flags_i(clr_flags),
      .tick_o(tick_w), .count_o(count_w), .count_sel_o(count_sel_w),
      .ovf_flags_o(ovf_w), .parity_o(parity_w));

   counter_bank #(.CHANNELS(4), .BITS(4), .LOG2DELAY(2), .SATURATE(1'b1)) dut_s (
      .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
      .ch_sel_i(ch_sel), .load_val_i(load_val), .clr_flags_i(clr_flags),
      .tick_o(tick_s), .count_o(count_s), .count_sel_o(count_sel_s),
      .ovf_flags_o(ovf_s), .parity_o(parity_s));

   counter_bank #(.CHANNELS(3), .BITS(4), .LOG2DELAY(2), .SATURATE(1'b0)) dut_t (
      .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
      .ch_sel_i(ch_sel), .load_val_i(load_val), .clr_flags_i(clr_flags),
      .tick_o(tick_t), .count_o(count_t), .count_sel_o(count_sel_t),
      .ovf_flags_o(ovf_t), .parity_o(parity_t));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock, then settle 1 time unit past the edge before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From prescaler 0, run three cycles with no tick and stop inside the
   // advance cycle. The first of them also checks the registered parity of
   // the count that was current before it.
   task automatic to_adv(input logic exp_par);
      for (int k = 0; k < 3; k++) begin
         step();
         check("tick_lo_w", tick_w, 1'b0);
         check("tick_lo_s", tick_s, 1'b0);
         if (k == 0) check("parity_w", parity_w, exp_par);
      end
   endtask

   task automatic adv_edge();
      step();
      check("tick_hi_w", tick_w, 1'b1);
      check("tick_hi_t", tick_t, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cnt_w"}, count_w, 16'h0);
      check({tag, "_cnt_s"}, count_s, 16'h0);
      check({tag, "_cnt_t"}, count_t, 12'h0);
      check({tag, "_ovf_w"}, ovf_w, 4'h0);
      check({tag, "_ovf_s"}, ovf_s, 4'h0);
      check({tag, "_tick"}, tick_w, 1'b0);
      check({tag, "_par_w"}, parity_w, 1'b0);
   endtask

   logic [15:0] k_a, k_b, k_c, k_d, k_e, k_f;

   initial begin
      k_a = 16'h4321; k_b = 16'h8642; k_c = 16'hC963;
      k_d = 16'h0C84; k_e = 16'hFC84; k_f = 16'h7F84;
      rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0;
      ch_sel = 2'd0; load_val = 4'd0; clr_flags = 1'b0;

      // Reset for two cycles.
      step(); step();
      check_zero("rst");

      // Count up, four ticks.
      rst = 1'b0; en = 1'b1; dir = 1'b1;
      to_adv(1'b0); adv_edge();
      check("t1_cnt_w", count_w, k_a);
      check("t1_cnt_s", count_s, k_a);
      check("t1_cnt_t", count_t, 12'h321);
      check("t1_ovf_w", ovf_w, 4'h0);
      to_adv(^k_a); adv_edge();
      check("t2_cnt_w", count_w, k_b);
      to_adv(^k_b); adv_edge();
      check("t3_cnt_w", count_w, k_c);
      to_adv(^k_c); adv_edge();
      check("t4_cnt_w", count_w, k_d);
      check("t4_cnt_s", count_s, k_e);
      check("t4_ovf_w", ovf_w, 4'b1000);
      check("t4_ovf_s", ovf_s, 4'b1000);
      ch_sel = 2'd3; #1;
      check("sel3_s", count_sel_s, 4'hF);
      check("sel3_t_oor", count_sel_t, 4'h0);

      // Clear flags in a quiet cycle.
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("clr_ovf_w", ovf_w, 4'h0);
      check("clr_ovf_s", ovf_s, 4'h0);
      check("clr_par_w", parity_w, ^k_d);
      check("clr_par_s", parity_s, ^k_e);
      step(); step();
      // Clear during an advance: saturated ch3 raises again and wins.
      clr_flags = 1'b1;
      adv_edge();
      clr_flags = 1'b0;
      check("t5_cnt_w", count_w, 16'h4FA5);
      check("t5_cnt_s", count_s, 16'hFFA5);
      check("t5_ovf_w", ovf_w, 4'h0);
      check("t5_ovf_s", ovf_s, 4'b1000);

      // Mid-period reset, then one down tick.
      step();
      rst = 1'b1;
      step();
      check_zero("rst2");
      rst = 1'b0; dir = 1'b0;
      to_adv(1'b0); adv_edge();
      check("dn_cnt_w", count_w, 16'hCDEF);
      check("dn_ovf_w", ovf_w, 4'hF);
      check("dn_cnt_s", count_s, 16'h0);
      check("dn_ovf_s", ovf_s, 4'hF);
      check("dn_ovf_t", ovf_t, 3'h7);

      // Loads beat advances on the selected channel only.
      rst = 1'b1;
      step();
      rst = 1'b0; dir = 1'b1;
      to_adv(1'b0); adv_edge();
      check("l1_cnt_w", count_w, k_a);
      to_adv(^k_a);
      load = 1'b1; ch_sel = 2'd2; load_val = 4'd9;
      adv_edge();
      load = 1'b0;
      check("l2_cnt_w", count_w, 16'h8942);
      check("l2_cnt_t", count_t, 12'h942);
      check("l2_ovf_w", ovf_w, 4'h0);
      check("l2_sel_w", count_sel_w, 4'd9);
      to_adv(^16'h8942); adv_edge();
      check("l3_cnt_w", count_w, 16'hCC63);
      to_adv(^16'hCC63);
      // ch3 would overflow here; the load must suppress that event.
      load = 1'b1; ch_sel = 2'd3; load_val = 4'd7;
      adv_edge();
      load = 1'b0;
      check("l4_cnt_w", count_w, k_f);
      check("l4_cnt_s", count_s, k_f);
      check("l4_ovf_s", ovf_s, 4'h0);
      check("l4_cnt_t_oor", count_t, 12'hF84);
      check("l4_sel_w", count_sel_w, 4'd7);
      check("l4_sel_t", count_sel_t, 4'd0);

      // Disabled: no tick, counts hold while dir toggles.
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         dir = ~dir;
         step();
         check("hold_tick", tick_w, 1'b0);
         check("hold_cnt", count_w, k_f);
         if (k == 0) check("hold_par", parity_w, ^k_f);
      end

      // Reset mid-period, then first tick exactly four cycles later.
      en = 1'b1; dir = 1'b1;
      step(); step();
      rst = 1'b1;
      step();
      check_zero("rst3");
      rst = 1'b0;
      to_adv(1'b0); adv_edge();
      check("r3_cnt_w", count_w, k_a);
      check("r3_cnt_s", count_s, k_a);
      step();
      check("r3_tick_lo", tick_w, 1'b0);
      check("r3_par", parity_w, ^k_a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised multi-channel successor to the single prescaled LED counter used in the benchmark designs.
- A shared free-running prescaler generates an advance strobe. On each strobe, every channel counter steps by its own increment, either up or down.
- Each channel can wrap or saturate, can be loaded individually, and reports sticky overflow flags.
- Sits between the board switch inputs and the LED outputs of the tool-perf test designs. It gives a scalable register and carry-chain load.

Parameters:
- CHANNELS, 4: number of independent counters. Legal range is 1 to 2^BITS-1.
- BITS, 4: width of each channel counter.
- LOG2DELAY, 22: prescaler width. The advance period is 2^LOG2DELAY cycles. Minimum value is 1.
- SATURATE, 0: 0 means counters wrap modulo 2^BITS. 1 means counters clamp at 2^BITS-1 (up) or 0 (down).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  prescaler enable.
- dir  in  1  1 = count up, 0 = count down; applies to all channels.
- load  in  1  load strobe for the channel selected by ch_sel.
- ch_sel  in  max(1,$clog2(CHANNELS))  channel index for load and for count_sel.
- load_val  in  BITS  value written on load.
- clr_flags  in  1  clears all overflow flags.
- tick  out  1  one-cycle pulse, high in the cycle after an advance.
- count  out  CHANNELS*BITS  all counters; channel i occupies bits [i*BITS +: BITS].
- count_sel  out  BITS  combinational mux of the count for channel ch_sel. Out-of-range ch_sel gives 0.
- ovf_flags  out  CHANNELS  sticky per-channel overflow/underflow flags.
- parity  out  1  XOR reduction of all bits of count, registered. It is one cycle behind count.

Behaviour:
- Reset
  - rst=1 at a clock edge sets prescaler, all counters, ovf_flags, tick and parity to 0.
  - rst overrides every other input.
  - Reset mid-count discards prescaler progress. The first advance after release occurs 2^LOG2DELAY enabled cycles later.
- Prescaler P (LOG2DELAY bits)
  - If en=1, P <= P+1, wrapping. If en=0, P holds.
  - adv = en & (P == 2^LOG2DELAY-1), evaluated combinationally in the same cycle.
  - tick <= adv, so tick is high for exactly 1 cycle per period.
- Channel i (0-based) on adv, with step s = i+1:
  - Up: sum = cnt + s, computed BITS+1 wide.
    - If sum >= 2^BITS: an overflow event.
    - With SATURATE=0, cnt <= sum mod 2^BITS.
    - With SATURATE=1, cnt <= 2^BITS-1.
  - Down: if cnt < s, an underflow event.
    - With SATURATE=0, cnt <= (cnt - s) mod 2^BITS.
    - With SATURATE=1, cnt <= 0.
  - Saturated at the limit and advanced again: value holds and the event is raised again (flag stays set).
  - No adv: cnt holds.
- Load
  - load=1 with ch_sel < CHANNELS writes load_val to that channel at the next edge, independent of en.
  - Load beats adv on the same channel in the same cycle. No event is raised for that channel.
  - Other channels still advance normally.
  - load with out-of-range ch_sel is ignored.
- Flags
  - ovf_flags[i] <= (ovf_flags[i] & ~clr_flags) | event_i.
  - A set event in the same cycle as clr_flags wins, so the flag ends up 1.
- dir may change at any time. It is sampled only on adv cycles.
- count reflects the updated values in the cycle tick is high.

Test Plan (CHANNELS=4, BITS=4, LOG2DELAY=2 unless stated):
1. rst for 2 cycles, then en=1, dir=1 -> tick pulses every 4th cycle. After 1st tick, count = {4,3,2,1} (ch3..ch0); ovf_flags=0000.
2. Continue to 4th tick -> ch0..ch3 = 4,8,12,0; ovf_flags=1000. Assert clr_flags for 1 cycle -> ovf_flags=0000.
3. SATURATE=1, dir=1, 5 ticks -> ch3 = 4,8,12,15,15; ovf_flags[3] set at tick 4. Repeat with clr_flags on an adv cycle -> flag remains 1.
4. From reset, dir=0, 1 tick -> ch0..ch3 = 15,14,13,12; ovf_flags=1111. With SATURATE=1 -> all 0, ovf_flags=1111.
5. load=1, ch_sel=2, load_val=9 in the adv cycle after tick 1 (dir=1) -> ch2=9, ch0=2, ch1=4, ch3=8; ovf_flags[2]=0. count_sel with ch_sel=2 reads 9.
6. Robustness sequence:
   - en=0 for 10 cycles -> no tick, counts hold.
   - Then rst pulse mid-period -> all outputs 0 next cycle.
   - en=1 -> first tick exactly 4 cycles after rst deasserts.
   - parity equals XOR of count, 1 cycle delayed, throughout.
